axi4_noburst_slave: RTL and testbench

AXI4_NOBURST_SLAVE -- requirements
Module: axi4_noburst_slave

---
 rtl/axi4_noburst_slave.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_axi4_noburst_slave.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_noburst_slave.sv
// AXI4 single-beat register slave: NUM_REGS x 32-bit registers, independent read/write FSMs.
// Define AXI4_NOBURST_SLAVE_STRICT_EN to answer SLVERR for AxLEN!=0 or AxSIZE>2.
module axi4_noburst_slave #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int NUM_REGS       = 16
) (
    input  logic                        clk,
    input  logic                        resetn,
    // write address
    input  logic [AXI_ADDR_WIDTH-1:0]   AWADDR,
    input  logic                        AWVALID,
    output logic                        AWREADY,
    input  logic [3:0]                  AWID,
    input  logic [7:0]                  AWLEN,
    input  logic [2:0]                  AWSIZE,
    input  logic [2:0]                  AWPROT,
    input  logic [1:0]                  AWBURST,
    input  logic                        AWLOCK,
    input  logic [3:0]                  AWCACHE,
    input  logic [3:0]                  AWQOS,
    // write data
    input  logic [AXI_DATA_WIDTH-1:0]   WDATA,
    input  logic [3:0]                  WSTRB,
    input  logic                        WLAST,
    input  logic                        WVALID,
    output logic                        WREADY,
    // write response
    output logic [1:0]                  BRESP,
    output logic [3:0]                  BID,
    output logic                        BVALID,
    input  logic                        BREADY,
    // read address
    input  logic [AXI_ADDR_WIDTH-1:0]   ARADDR,
    input  logic                        ARVALID,
    output logic                        ARREADY,
    input  logic [3:0]                  ARID,
    input  logic [7:0]                  ARLEN,
    input  logic [2:0]                  ARSIZE,
    input  logic [2:0]                  ARPROT,
    input  logic [1:0]                  ARBURST,
    input  logic                        ARLOCK,
    input  logic [3:0]                  ARCACHE,
    input  logic [3:0]                  ARQOS,
    // read data
    output logic [AXI_DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]                  RRESP,
    output logic [3:0]                  RID,
    output logic                        RLAST,
    output logic                        RVALID,
    input  logic                        RREADY,
    // register view
    output logic [32*NUM_REGS-1:0]      REGS,
    output logic [NUM_REGS-1:0]         WR_STROBE
);

    localparam int IDX_W = AXI_ADDR_WIDTH - 2;
    localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { W_ACCEPT, W_RESP } w_state_e;
    typedef enum logic { R_ACCEPT, R_DATA } r_state_e;

    w_state_e                   w_state_q, w_state_d;
    r_state_e                   r_state_q, r_state_d;
    logic                       awready_q, awready_d;
    logic                       wready_q, wready_d;
    logic                       aw_held_q, aw_held_d;
    logic                       w_held_q, w_held_d;
    logic [IDX_W-1:0]           aw_idx_q, aw_idx_d;
    logic [3:0]                 aw_id_q, aw_id_d;
    logic                       aw_bad_q, aw_bad_d;
    logic [AXI_DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [3:0]                 wstrb_q, wstrb_d;
    logic                       bvalid_q, bvalid_d;
    logic [1:0]                 bresp_q, bresp_d;
    logic [3:0]                 bid_q, bid_d;
    logic [NUM_REGS-1:0]        wr_strobe_q, wr_strobe_d;
    logic [31:0]                regs_q [NUM_REGS];
    logic [31:0]                regs_d [NUM_REGS];
    logic                       arready_q, arready_d;
    logic                       rvalid_q, rvalid_d;
    logic [AXI_DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [1:0]                 rresp_q, rresp_d;
    logic [3:0]                 rid_q, rid_d;
    logic                       rlast_q, rlast_d;

    logic                       aw_hs, w_hs, ar_hs;
    logic                       aw_bad_in, ar_bad_in;
    logic [IDX_W-1:0]           eff_idx, ar_idx;
    logic [SEL_W-1:0]           eff_sel, ar_sel;
    logic [3:0]                 eff_id;
    logic                       eff_bad;
    logic [AXI_DATA_WIDTH-1:0]  eff_data;
    logic [3:0]                 eff_strb;
    logic                       have_aw, have_w, wr_err, rd_err;
    logic                       unused_ok;

    function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
        return 64'(idx) < 64'(NUM_REGS);
    endfunction

`ifdef AXI4_NOBURST_SLAVE_STRICT_EN
    assign aw_bad_in = (AWLEN != 8'd0) || (AWSIZE > 3'd2);
    assign ar_bad_in = (ARLEN != 8'd0) || (ARSIZE > 3'd2);
    assign unused_ok = ^{AWADDR[1:0], ARADDR[1:0], WLAST, AWPROT, AWBURST, AWLOCK, AWCACHE,
                         AWQOS, ARPROT, ARBURST, ARLOCK, ARCACHE, ARQOS};
`else
    assign aw_bad_in = 1'b0;
    assign ar_bad_in = 1'b0;
    assign unused_ok = ^{AWADDR[1:0], ARADDR[1:0], WLAST, AWPROT, AWBURST, AWLOCK, AWCACHE,
                         AWQOS, ARPROT, ARBURST, ARLOCK, ARCACHE, ARQOS,
                         AWLEN, AWSIZE, ARLEN, ARSIZE};
`endif

    assign aw_hs = AWVALID && awready_q;
    assign w_hs  = WVALID && wready_q;
    assign ar_hs = ARVALID && arready_q;

    // Commit may happen on the same edge as the second capture, so mux live inputs over held copies.
    assign have_aw  = aw_held_q || aw_hs;
    assign have_w   = w_held_q || w_hs;
    assign eff_idx  = aw_held_q ? aw_idx_q : AWADDR[AXI_ADDR_WIDTH-1:2];
    assign eff_id   = aw_held_q ? aw_id_q : AWID;
    assign eff_bad  = aw_held_q ? aw_bad_q : aw_bad_in;
    assign eff_data = w_held_q ? wdata_q : WDATA;
    assign eff_strb = w_held_q ? wstrb_q : WSTRB;
    assign eff_sel  = eff_idx[SEL_W-1:0];
    assign wr_err   = !idx_ok(eff_idx) || eff_bad;

    assign ar_idx   = ARADDR[AXI_ADDR_WIDTH-1:2];
    assign ar_sel   = ar_idx[SEL_W-1:0];
    assign rd_err   = !idx_ok(ar_idx) || ar_bad_in;

    // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
    always_comb begin
        w_state_d   = w_state_q;
        awready_d   = awready_q;
        wready_d    = wready_q;
        aw_held_d   = aw_held_q;
        w_held_d    = w_held_q;
        aw_idx_d    = aw_idx_q;
        aw_id_d     = aw_id_q;
        aw_bad_d    = aw_bad_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        bid_d       = bid_q;
        wr_strobe_d = '0;
        regs_d      = regs_q;

        case (w_state_q)
            W_ACCEPT: begin
                awready_d = !have_aw;
                wready_d  = !have_w;
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    aw_idx_d  = AWADDR[AXI_ADDR_WIDTH-1:2];
                    aw_id_d   = AWID;
                    aw_bad_d  = aw_bad_in;
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = WDATA;
                    wstrb_d  = WSTRB;
                end
                if (have_aw && have_w) begin
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    bid_d     = eff_id;
                    bresp_d   = wr_err ? RESP_SLVERR : RESP_OKAY;
                    w_state_d = W_RESP;
                    if (!wr_err) begin
                        for (int b = 0; b < 4; b++) begin
                            if (eff_strb[b]) regs_d[eff_sel][8*b +: 8] = eff_data[8*b +: 8];
                        end
                        wr_strobe_d[eff_sel] = |eff_strb;
                    end
                end
            end
            W_RESP: begin
                awready_d = 1'b0;
                wready_d  = 1'b0;
                if (bvalid_q && BREADY) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    w_state_d = W_ACCEPT;
                end
            end
            default: w_state_d = W_ACCEPT;
        endcase
    end

    // Reads sample regs_q, so a read racing a commit to the same register sees the old value.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rid_d     = rid_q;
        rlast_d   = rlast_q;

        case (r_state_q)
            R_ACCEPT: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rlast_d   = 1'b1;
                    rid_d     = ARID;
                    rresp_d   = rd_err ? RESP_SLVERR : RESP_OKAY;
                    rdata_d   = rd_err ? '0 : regs_q[ar_sel];
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                arready_d = 1'b0;
                if (rvalid_q && RREADY) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_ACCEPT;
                end
            end
            default: r_state_d = R_ACCEPT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            w_state_q   <= W_ACCEPT;
            r_state_q   <= R_ACCEPT;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            aw_held_q   <= 1'b0;
            w_held_q    <= 1'b0;
            aw_idx_q    <= '0;
            aw_id_q     <= '0;
            aw_bad_q    <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            bvalid_q    <= 1'b0;
            bresp_q     <= '0;
            bid_q       <= '0;
            wr_strobe_q <= '0;
            // NOTE: the register file is architecturally visible and must read 0 after reset,
            // so it is built from resettable flops rather than a RAM macro.
            regs_q      <= '{default: '0};
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= '0;
            rid_q       <= '0;
            rlast_q     <= 1'b0;
        end else begin
            w_state_q   <= w_state_d;
            r_state_q   <= r_state_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            aw_held_q   <= aw_held_d;
            w_held_q    <= w_held_d;
            aw_idx_q    <= aw_idx_d;
            aw_id_q     <= aw_id_d;
            aw_bad_q    <= aw_bad_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            bid_q       <= bid_d;
            wr_strobe_q <= wr_strobe_d;
            regs_q      <= regs_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            rid_q       <= rid_d;
            rlast_q     <= rlast_d;
        end
    end

    assign AWREADY   = awready_q;
    assign WREADY    = wready_q;
    assign BVALID    = bvalid_q;
    assign BRESP     = bresp_q;
    assign BID       = bid_q;
    assign ARREADY   = arready_q;
    assign RVALID    = rvalid_q;
    assign RDATA     = rdata_q;
    assign RRESP     = rresp_q;
    assign RID       = rid_q;
    assign RLAST     = rlast_q;
    assign WR_STROBE = wr_strobe_q;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
        assign REGS[32*gi +: 32] = regs_q[gi];
    end

endmodule

// File: tb/tb_axi4_noburst_slave.sv
// Directed bench for axi4_noburst_slave: scoreboard queues for B and R, register model for data.
module tb_axi4_noburst_slave;

    localparam int NR = 16;

    logic        clk;
    logic        resetn;
    logic [31:0] AWADDR;
    logic        AWVALID, AWREADY;
    logic [3:0]  AWID;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST, WVALID, WREADY;
    logic [1:0]  BRESP;
    logic [3:0]  BID;
    logic        BVALID, BREADY;
    logic [31:0] ARADDR;
    logic        ARVALID, ARREADY;
    logic [3:0]  ARID;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic [3:0]  RID;
    logic        RLAST, RVALID, RREADY;
    logic [32*NR-1:0] REGS;
    logic [NR-1:0]    WR_STROBE;

    axi4_noburst_slave #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .NUM_REGS(NR)) dut (
        .clk(clk), .resetn(resetn),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWLEN(AWLEN),
        .AWSIZE(AWSIZE), .AWPROT(3'd0), .AWBURST(2'b01), .AWLOCK(1'b0), .AWCACHE(4'd0),
        .AWQOS(4'd0),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BID(BID), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARLEN(ARLEN),
        .ARSIZE(ARSIZE), .ARPROT(3'd0), .ARBURST(2'b01), .ARLOCK(1'b0), .ARCACHE(4'd0),
        .ARQOS(4'd0),
        .RDATA(RDATA), .RRESP(RRESP), .RID(RID), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .REGS(REGS), .WR_STROBE(WR_STROBE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct { logic [31:0] data; logic [1:0] resp; logic [3:0] id; } r_exp_t;

    b_exp_t      b_q[$];
    r_exp_t      r_q[$];
    logic [31:0] mdl [NR];
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic in_range(input logic [31:0] addr);
        return (addr >> 2) < NR;
    endfunction

    // Expected write outcome and model update, computed from the address/strobe alone.
    task automatic expect_write(input logic [31:0] addr, input logic [31:0] data,
                                input logic [3:0] strb, input logic [3:0] id);
        b_exp_t e;
        e.id   = id;
        e.resp = in_range(addr) ? 2'b00 : 2'b10;
        b_q.push_back(e);
        if (in_range(addr)) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) mdl[addr >> 2][8*b +: 8] = data[8*b +: 8];
        end
    endtask

    task automatic expect_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
        r_exp_t e;
        logic   err;
        err = !in_range(addr);
`ifdef AXI4_NOBURST_SLAVE_STRICT_EN
        if (len != 8'd0) err = 1'b1;
`else
        if (len != 8'd0) err = err;
`endif
        e.id   = id;
        e.resp = err ? 2'b10 : 2'b00;
        e.data = err ? 32'd0 : mdl[addr >> 2];
        r_q.push_back(e);
    endtask

    task automatic send_aw_w(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [3:0] id);
        logic got;
        expect_write(addr, data, strb, id);
        AWADDR = addr; AWID = id; AWVALID = 1'b1;
        WDATA = data; WSTRB = strb; WVALID = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (AWREADY && WREADY) begin got = 1'b1; break; end
            tick();
        end
        check("aw_w_accept", got, 1'b1);
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
        logic got;
        expect_read(addr, id, len);
        ARADDR = addr; ARID = id; ARLEN = len; ARVALID = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ARREADY) begin got = 1'b1; break; end
            tick();
        end
        check("ar_accept", got, 1'b1);
        tick();
        ARVALID = 1'b0; ARLEN = 8'd0;
    endtask

    task automatic collect_b(input string tag);
        logic   got;
        b_exp_t e;
        BREADY = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (BVALID) begin got = 1'b1; break; end
            tick();
        end
        check({tag, "_bvalid"}, got, 1'b1);
        check({tag, "_b_sb"}, b_q.size() != 0, 1'b1);
        if (got && b_q.size() != 0) begin
            e = b_q.pop_front();
            check({tag, "_bid"}, BID, e.id);
            check({tag, "_bresp"}, BRESP, e.resp);
        end
        tick();
        BREADY = 1'b0;
    endtask

    task automatic collect_r(input string tag);
        logic   got;
        r_exp_t e;
        RREADY = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (RVALID) begin got = 1'b1; break; end
            tick();
        end
        check({tag, "_rvalid"}, got, 1'b1);
        check({tag, "_r_sb"}, r_q.size() != 0, 1'b1);
        if (got && r_q.size() != 0) begin
            e = r_q.pop_front();
            check({tag, "_rdata"}, RDATA, e.data);
            check({tag, "_rresp"}, RRESP, e.resp);
            check({tag, "_rid"}, RID, e.id);
            check({tag, "_rlast"}, RLAST, 1'b1);
            check({tag, "_arready_busy"}, ARREADY, 1'b0);
        end
        tick();
        RREADY = 1'b0;
    endtask

    task automatic check_regs_zero(input string tag);
        for (int i = 0; i < NR; i++) check(tag, REGS[32*i +: 32], 32'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        AWADDR = '0; AWVALID = 1'b0; AWID = '0; AWLEN = '0; AWSIZE = 3'd2;
        WDATA = '0; WSTRB = '0; WLAST = 1'b1; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR = '0; ARVALID = 1'b0; ARID = '0; ARLEN = '0; ARSIZE = 3'd2; RREADY = 1'b0;
        for (int i = 0; i < NR; i++) mdl[i] = 32'd0;

        // Reset state
        tick(); tick(); tick();
        check("rst_awready", AWREADY, 1'b0);
        check("rst_wready", WREADY, 1'b0);
        check("rst_arready", ARREADY, 1'b0);
        check("rst_bvalid", BVALID, 1'b0);
        check("rst_rvalid", RVALID, 1'b0);
        check("rst_strobe", WR_STROBE, '0);
        check("rst_rdata", RDATA, 32'd0);
        check_regs_zero("rst_regs");
        resetn = 1'b1;
        tick();
        check("post_rst_awready", AWREADY, 1'b1);
        check("post_rst_wready", WREADY, 1'b1);
        check("post_rst_arready", ARREADY, 1'b1);

        // AW and W together, then read back
        send_aw_w(32'h04, 32'hA1B1C1D1, 4'hF, 4'h2);
        check("w29_strobe", WR_STROBE, 16'h0002);
        check("w29_awready_resp", AWREADY, 1'b0);
        check("w29_wready_resp", WREADY, 1'b0);
        tick();
        check("w29_strobe_1cyc", WR_STROBE, 16'h0000);
        collect_b("w29");
        check("w29_b2b_awready", AWREADY, 1'b1);
        send_ar(32'h04, 4'h3, 8'd0);
        collect_r("r29");

        // W three cycles ahead of AW, then partial-strobe write
        WDATA = 32'h11223344; WSTRB = 4'hF; WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("w30_no_bvalid", BVALID, 1'b0);
            check("w30_wready_held", WREADY, 1'b0);
            tick();
        end
        check("w30_awready_wait", AWREADY, 1'b1);
        expect_write(32'h08, 32'h11223344, 4'hF, 4'h4);
        AWADDR = 32'h08; AWID = 4'h4; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        check("w30_bvalid_after_aw", BVALID, 1'b1);
        check("w30_strobe", WR_STROBE, 16'h0004);
        collect_b("w30a");
        send_aw_w(32'h08, 32'h0000FFFF, 4'h3, 4'h5);
        collect_b("w30b");
        send_ar(32'h08, 4'h6, 8'd0);
        collect_r("r30");

        // Out-of-range write and read
        send_aw_w(32'h40, 32'hDEADBEEF, 4'hF, 4'h1);
        check("w31_no_strobe", WR_STROBE, 16'h0000);
        collect_b("w31");
        send_ar(32'h40, 4'h9, 8'd0);
        collect_r("r31");

        // Back-pressured B with AWID=7
        send_aw_w(32'h0C, 32'hCAFEF00D, 4'hF, 4'h7);
        for (int i = 0; i < 5; i++) begin
            check("w32_bvalid_hold", BVALID, 1'b1);
            check("w32_bid_hold", BID, 4'h7);
            check("w32_awready_low", AWREADY, 1'b0);
            check("w32_wready_low", WREADY, 1'b0);
            tick();
        end
        collect_b("w32");
        check("w32_next_awready", AWREADY, 1'b1);
        send_aw_w(32'h0C, 32'h12345678, 4'b1100, 4'h8);
        collect_b("w32b");

        // Zero-strobe write: OKAY, no strobe pulse
        send_aw_w(32'h10, 32'hFFFFFFFF, 4'h0, 4'h9);
        check("wz_no_strobe", WR_STROBE, 16'h0000);
        collect_b("wz");

        // Read and write commit to register 1 on the same edge
        expect_read(32'h04, 4'hB, 8'd0);
        expect_write(32'h04, 32'h55555555, 4'hF, 4'hA);
        AWADDR = 32'h04; AWID = 4'hA; AWVALID = 1'b1;
        WDATA = 32'h55555555; WSTRB = 4'hF; WVALID = 1'b1;
        ARADDR = 32'h04; ARID = 4'hB; ARVALID = 1'b1;
        check("race_all_ready", {AWREADY, WREADY, ARREADY}, 3'b111);
        tick();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        check("race_strobe", WR_STROBE, 16'h0002);
        collect_r("race_r");
        collect_b("race_b");
        send_ar(32'h04, 4'hC, 8'd0);
        collect_r("race_after");
        send_ar(32'h0C, 4'hD, 8'd0);
        collect_r("r_reg3");

        // ARLEN=3: SLVERR only in the strict build
        send_ar(32'h04, 4'hE, 8'd3);
        collect_r("r33_len");

        // Reset while a write response is pending
        send_aw_w(32'h14, 32'h0BADC0DE, 4'hF, 4'hD);
        check("w33_bvalid_pending", BVALID, 1'b1);
        resetn = 1'b0;
        tick();
        check("w33_bvalid_cleared", BVALID, 1'b0);
        check("w33_awready_rst", AWREADY, 1'b0);
        check("w33_strobe_rst", WR_STROBE, 16'h0000);
        check("w33_bid_rst", BID, 4'h0);
        check_regs_zero("w33_regs");
        if (b_q.size() != 0) void'(b_q.pop_back());
        for (int i = 0; i < NR; i++) mdl[i] = 32'd0;
        resetn = 1'b1;
        tick();
        check("w33_ready_after", {AWREADY, WREADY, ARREADY}, 3'b111);
        send_aw_w(32'h00, 32'h0F0F0F0F, 4'hF, 4'h3);
        collect_b("w33_recover");
        send_ar(32'h00, 4'h4, 8'd0);
        collect_r("r33_recover");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
